// File: rtl/ram_bus_pkg.sv
// Shared constants for the 8 KB RAM bus initiator: widths, FSM state codes, burst direction.
package ram_bus_pkg;

  localparam int RAM_ADDR_W = 13;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_LEN_W  = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_READ_TAIL = 3'd3;
  localparam logic [2:0] ST_TURN      = 3'd4;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  function automatic logic [2:0] burst_state(input logic dir);
    return (dir == DIR_WRITE) ? ST_WRITE : ST_READ;
  endfunction

endpackage

// File: rtl/ram8k_bus_master.sv
// Burst initiator for the 8 KB single-port RAM tri-state bus (ce/oce/wre/ad/data_bus).
// Optional macro RAM_MASTER_STATS_EN adds saturating beat counters stat_wr_beats/stat_rd_beats.
module ram8k_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = RAM_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              ce,
  output logic              oce,
  output logic              wre,
  output logic [ADDR_W-1:0] ad,
  inout  wire  [DATA_W-1:0] data_bus
`ifdef RAM_MASTER_STATS_EN
  ,
  output logic [15:0]       stat_wr_beats,
  output logic [15:0]       stat_rd_beats
`endif
);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              dir_reg, dir_next;
  logic              dir_valid_reg, dir_valid_next;
  logic              first_reg, first_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              capture;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    cnt_next       = cnt_reg;
    dir_next       = dir_reg;
    dir_valid_next = dir_valid_reg;
    first_next     = first_reg;
    done_next      = 1'b0;
    capture        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_next      = cmd_addr;
          cnt_next       = cmd_len;
          dir_next       = cmd_write;
          dir_valid_next = 1'b1;
          first_next     = 1'b1;
          // A direction change gets one dead cycle so RAM and master never overlap on data_bus
          state_next = (dir_valid_reg && (dir_reg != cmd_write)) ? ST_TURN : burst_state(cmd_write);
        end
      end
      ST_TURN: state_next = burst_state(dir_reg);
      ST_WRITE: begin
        if (wr_valid) begin
          addr_next = addr_reg + ADDR_W'(1);
          if (cnt_reg == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg - LEN_W'(1);
          end
        end
      end
      ST_READ: begin
        // RAM data lags the address by one cycle, so the first address cycle has nothing to capture
        first_next = 1'b0;
        capture    = !first_reg;
        if (cnt_reg == '0) begin
          state_next = ST_READ_TAIL;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
          cnt_next  = cnt_reg - LEN_W'(1);
        end
      end
      ST_READ_TAIL: begin
        capture    = 1'b1;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      dir_reg       <= DIR_READ;
      dir_valid_reg <= 1'b0;
      first_reg     <= 1'b0;
      done_reg      <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      dir_reg       <= dir_next;
      dir_valid_reg <= dir_valid_next;
      first_reg     <= first_next;
      done_reg      <= done_next;
      rd_valid_reg  <= capture;
      if (capture) rd_data_reg <= data_bus;
    end
  end

  assign wre       = (state_reg == ST_WRITE) && wr_valid;
  assign wr_ready  = wre;
  assign oce       = (state_reg == ST_READ) || (state_reg == ST_READ_TAIL);
  assign ce        = wre || oce;
  assign ad        = ((state_reg == ST_WRITE) || oce) ? addr_reg : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign cmd_ready = (state_reg == ST_IDLE) && !reset;
  assign done      = done_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign data_bus  = (ce && wre) ? wr_data : {DATA_W{1'bz}};

`ifdef RAM_MASTER_STATS_EN
  logic [15:0] stat_wr_reg, stat_rd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_wr_reg <= '0;
      stat_rd_reg <= '0;
    end else begin
      if (wre && (stat_wr_reg != 16'hFFFF)) stat_wr_reg <= stat_wr_reg + 16'd1;
      if (rd_valid_reg && (stat_rd_reg != 16'hFFFF)) stat_rd_reg <= stat_rd_reg + 16'd1;
    end
  end

  assign stat_wr_beats = stat_wr_reg;
  assign stat_rd_beats = stat_rd_reg;
`endif

endmodule

// File: tb/tb_ram8k_bus_master.sv
// Directed bench for ram8k_bus_master with a registered-read RAM model on data_bus and
// scoreboard queues for expected write beats and read beats.
module tb_ram8k_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        ce;
  logic        oce;
  logic        wre;
  logic [12:0] ad;
  wire  [7:0]  data_bus;
`ifdef RAM_MASTER_STATS_EN
  logic [15:0] stat_wr_beats;
  logic [15:0] stat_rd_beats;
`endif

  ram8k_bus_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .ce(ce), .oce(oce), .wre(wre), .ad(ad), .data_bus(data_bus)
`ifdef RAM_MASTER_STATS_EN
    , .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: writes at the edge, read data presented on the bus the cycle after the address
  logic [7:0] mem [0:8191];
  logic [7:0] ram_q;
  logic       ram_oe;
  always @(posedge clk) begin
    if (ce && wre) mem[ad] <= data_bus;
    ram_oe <= ce && oce && !wre;
    if (ce && oce && !wre) ram_q <= mem[ad];
  end
  assign data_bus = ram_oe ? ram_q : 8'hzz;

  int          total = 0;
  int          bad = 0;
  int          rv_count = 0;
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [7:0]  ref_mem [0:8191];
  logic [20:0] wq [$];
  logic [20:0] rq [$];
  logic [12:0] ad_d1 = '0;
  logic [12:0] ad_d2 = '0;
  logic [7:0]  wdat [0:7];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk13(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Per-cycle monitor: called once after the inputs of a cycle have been driven
  task automatic mon();
    logic [20:0] e;
    #1;
    if (rd_valid) begin
      rv_count++;
      if (rq.size() == 0) chk1("rd_unexpected", rd_valid, 1'b0);
      else begin
        e = rq.pop_front();
        chk8("rd_data", rd_data, e[7:0]);
        chk13("rd_latency_ad", ad_d2, e[20:8]);
        $display("read  beat addr=%h data=%h", e[20:8], rd_data);
      end
    end
    if (ce && wre) begin
      if (wq.size() == 0) chk1("wr_unexpected", wre, 1'b0);
      else begin
        e = wq.pop_front();
        chk13("wr_ad", ad, e[20:8]);
        chk8("wr_bus", data_bus, e[7:0]);
        $display("write beat addr=%h data=%h", ad, data_bus);
      end
    end
    if (ram_oe === 1'b1) chk8("bus_ram_value", data_bus, ram_q);
    ad_d2 = ad_d1;
    ad_d1 = ad;
  endtask

  task automatic send_cmd(input logic w, input logic [12:0] a, input logic [7:0] len);
    int n = 0;
    do begin
      step();
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
      mon();
      n++;
    end while (!cmd_ready && n < 100);
    chk1("cmd_accept", cmd_ready, 1'b1);
  endtask

  task automatic write_burst(input logic [12:0] a, input int len, input int gap_at,
                             input int gap_len, input bit turn);
    int beat = 0, gap = 0, n = 0;
    logic [12:0] ea;
    for (int k = 0; k <= len; k++) begin
      ea = a + k[12:0];
      wq.push_back({ea, wdat[k]});
      ref_mem[ea] = wdat[k];
    end
    exp_wr += len + 1;
    wr_valid = 1'b0;
    send_cmd(1'b1, a, len[7:0]);
    while (beat <= len && n < 200) begin
      step();
      cmd_valid = 1'b0;
      if (beat == gap_at && gap < gap_len) begin
        wr_valid = 1'b0; gap++;
      end else begin
        wr_valid = 1'b1; wr_data = wdat[beat];
      end
      mon();
      if (n == 0) chk1("wr_first_ce", ce, !turn);
      if (!wr_valid) begin
        ea = a + beat[12:0];
        chk1("bubble_ce", ce, 1'b0);
        chk13("bubble_ad", ad, ea);
      end
      if (wr_ready) beat++;
      n++;
    end
    chkn("wr_beats_taken", beat, len + 1);
    step();
    wr_valid = 1'b0;
    mon();
    chk1("wr_done", done, 1'b1);
    chk1("wr_idle_ready", cmd_ready, 1'b1);
    chkn("wq_drained", wq.size(), 0);
    $display("write burst addr=%h len=%0d complete", a, len);
  endtask

  task automatic read_burst(input logic [12:0] a, input int len, input bit turn);
    int n = 0, ce_cyc = 0, rv0, first_rv = -1, last_rv = -1;
    bit got_done = 1'b0;
    logic [12:0] ea;
    rv0 = rv_count;
    for (int k = 0; k <= len; k++) begin
      ea = a + k[12:0];
      rq.push_back({ea, ref_mem[ea]});
    end
    exp_rd += len + 1;
    wr_valid = 1'b0;
    wr_data = 8'hFF;
    send_cmd(1'b0, a, len[7:0]);
    while (!got_done && n < 600) begin
      step();
      cmd_valid = 1'b0;
      mon();
      if (n == 0) chk1("rd_first_ce", ce, !turn);
      if (ce) begin
        ce_cyc++;
        chk1("rd_oce", oce, 1'b1);
        chk1("rd_wre", wre, 1'b0);
      end
      if (rd_valid) begin
        if (first_rv < 0) first_rv = n;
        last_rv = n;
      end
      if (done) begin
        got_done = 1'b1;
        chk1("rd_done_with_last_valid", rd_valid, 1'b1);
      end
      n++;
    end
    chk1("rd_done_seen", got_done, 1'b1);
    chkn("rd_ce_cycles", ce_cyc, len + 2);
    chkn("rd_valid_pulses", rv_count - rv0, len + 1);
    chkn("rd_consecutive", last_rv - first_rv, len);
    step();
    mon();
    chk1("rd_valid_one_cycle", rd_valid, 1'b0);
    chk1("rd_done_one_cycle", done, 1'b0);
    chkn("rq_drained", rq.size(), 0);
    $display("read  burst addr=%h len=%0d complete", a, len);
  endtask

  initial begin
    int n;
    int beat;
    logic [12:0] ea;

    // Reset state
    repeat (3) step();
    step(); mon();
    chk1("reset_cmd_ready", cmd_ready, 1'b0);
    chk1("reset_ce", ce, 1'b0);
    chk1("reset_wre", wre, 1'b0);
    reset = 1'b0;
    step(); mon();
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk1("idle_rd_valid", rd_valid, 1'b0);
    chk8("idle_rd_data", rd_data, 8'h00);
    chk13("idle_ad", ad, 13'h0000);
    chk1("idle_wr_ready", wr_ready, 1'b0);
    chk1("idle_oce", oce, 1'b0);

    // 1: single write then read with direction turnaround
    wdat[0] = 8'hA5;
    write_burst(13'h0100, 0, -1, 0, 1'b0);
    read_burst(13'h0100, 0, 1'b1);

    // 2: burst across the address wrap
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    write_burst(13'h1FFE, 3, -1, 0, 1'b1);
    read_burst(13'h1FFE, 3, 1'b1);

    // 3: two-cycle write bubble after the first beat
    wdat[0] = 8'h5A; wdat[1] = 8'h6B; wdat[2] = 8'h7C; wdat[3] = 8'h8D;
    write_burst(13'h0200, 3, 1, 2, 1'b1);
    read_burst(13'h0200, 3, 1'b1);

    // 4: eight-beat read
    for (int k = 0; k < 8; k++) wdat[k] = 8'h90 + 8'(k);
    write_burst(13'h0300, 7, -1, 0, 1'b1);
    read_burst(13'h0300, 7, 1'b1);

`ifdef RAM_MASTER_STATS_EN
    step(); mon();
    chkn("stat_wr_beats", int'(stat_wr_beats), exp_wr);
    chkn("stat_rd_beats", int'(stat_rd_beats), exp_rd);
`endif

    // 5: reset during beat 2 of an eight-beat write
    for (int k = 0; k < 8; k++) wdat[k] = 8'hC0 + 8'(k);
    for (int k = 0; k < 3; k++) begin
      ea = 13'h0400 + 13'(k);
      wq.push_back({ea, wdat[k]});
      ref_mem[ea] = wdat[k];
    end
    send_cmd(1'b1, 13'h0400, 8'd7);
    beat = 0; n = 0;
    while (n < 50) begin
      step();
      cmd_valid = 1'b0;
      wr_valid = 1'b1;
      wr_data = wdat[beat];
      if (beat == 2) reset = 1'b1;
      mon();
      if (reset) break;
      if (wr_ready) beat++;
      n++;
    end
    chk1("rst_reached_beat2", reset, 1'b1);
    step(); mon();
    chk1("rst_ce", ce, 1'b0);
    chk1("rst_oce", oce, 1'b0);
    chk1("rst_wre", wre, 1'b0);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_cmd_ready_held", cmd_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); mon();
      chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
      chk1("post_rst_no_done", done, 1'b0);
    end
    chkn("rst_wq_drained", wq.size(), 0);
    $display("reset abort of write burst addr=0400 checked");
    exp_wr = 0;
    exp_rd = 0;

    // 6: write command held while a read burst is running
    for (int k = 0; k < 4; k++) begin
      ea = 13'h1FFE + 13'(k);
      rq.push_back({ea, ref_mem[ea]});
    end
    exp_rd += 4;
    send_cmd(1'b0, 13'h1FFE, 8'd3);
    wq.push_back({13'h0800, 8'h6C});
    ref_mem[13'h0800] = 8'h6C;
    exp_wr += 1;
    n = 0;
    while (n < 50) begin
      step();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h0800; cmd_len = 8'd0;
      wr_valid = 1'b1; wr_data = 8'h6C;
      mon();
      if (n == 0) chk1("t6_no_turn_after_reset", ce, 1'b1);
      if (busy) begin
        chk1("held_cmd_ready_busy", cmd_ready, 1'b0);
        chk1("held_wr_ready_read", wr_ready, 1'b0);
      end else begin
        chk1("held_cmd_ready_idle", cmd_ready, 1'b1);
        chk1("held_idle_done", done, 1'b1);
        break;
      end
      n++;
    end
    step();
    cmd_valid = 1'b0;
    mon();
    chk1("held_accept_busy", busy, 1'b1);
    chk1("held_turn_ce", ce, 1'b0);
    step(); mon();
    chk1("held_write_beat", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    mon();
    chk1("held_write_done", done, 1'b1);
    chkn("t6_rq_drained", rq.size(), 0);
    chkn("t6_wq_drained", wq.size(), 0);
    $display("held command accepted in first idle cycle");

    read_burst(13'h0800, 0, 1'b1);

`ifdef RAM_MASTER_STATS_EN
    step(); mon();
    chkn("stat_wr_beats_after_rst", int'(stat_wr_beats), exp_wr);
    chkn("stat_rd_beats_after_rst", int'(stat_rd_beats), exp_rd);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
